// File: rtl/wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
//
// Purpose:
//    Shares one Wishbone classic slave port between two masters. Arbitration
//    is round-robin: on a tie, the master that did not own the bus most
//    recently wins. A granted master keeps the bus for as long as it holds
//    cyc, so multi-strobe and locked sequences are never split. A watchdog
//    ends a strobe that the slave never acks: it pulses err to the owner and
//    drops the slave strobe for that one cycle.
//
// Parameters:
//    timeout_cycles : unacked strobe cycles before err fires (0 = watchdog off)
//
// Ports:
//    clk                    : system clock, rising edge
//    rst                    : asynchronous reset, active low
//    m0_*_i / m1_*_i        : master requests (adr, dat, sel, we, cyc, stb)
//    m0_dat_o / m1_dat_o    : read data, both driven from s_dat_i
//    m0_ack_o / m1_ack_o    : slave ack, routed to the granted master only
//    m0_err_o / m1_err_o    : watchdog error, routed to the granted master only
//    s_*_o                  : slave-side request, muxed from the granted master
//    s_dat_i / s_ack_i      : slave read data and ack
//    grant_o                : one-hot grant from the state register
//                             (bit0 = m0, bit1 = m1)
// -----------------------------------------------------------------------------
module wb_rr_arbiter #(
   parameter logic [15:0] timeout_cycles = 16'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   output logic [31:0] m0_dat_o,
   input  logic [3:0]  m0_sel_i,
   input  logic        m0_we_i,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   output logic [31:0] m1_dat_o,
   input  logic [3:0]  m1_sel_i,
   input  logic        m1_we_i,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   output logic [3:0]  s_sel_o,
   output logic        s_we_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,
   output logic [1:0]  grant_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        last_gnt;
   logic        last_gnt_next;
   logic [15:0] wd;
   logic [15:0] wd_next;
   logic        raw_stb;
   logic        timeout_hit;

   // State, last owner and watchdog registers. last_gnt resets to m1 so
   // that m0 wins the first tie after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         last_gnt <= 1'b1;
         wd       <= 16'd0;
      end else begin
         state    <= state_next;
         last_gnt <= last_gnt_next;
         wd       <= wd_next;
      end
   end

   // Next-state logic. A granted master keeps the bus until it drops cyc;
   // the release always passes through IDLE, which gives one dead cycle
   // between owners.
   always_comb begin
      state_next    = state;
      last_gnt_next = last_gnt;
      case (state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               state_next = last_gnt ? GNT0 : GNT1;
            end else if (m0_cyc_i) begin
               state_next = GNT0;
            end else if (m1_cyc_i) begin
               state_next = GNT1;
            end
         end
         GNT0: begin
            if (!m0_cyc_i) begin
               state_next    = IDLE;
               last_gnt_next = 1'b0;
            end
         end
         GNT1: begin
            if (!m1_cyc_i) begin
               state_next    = IDLE;
               last_gnt_next = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Slave-side request mux, driven from the registered state so the slave
   // sees nothing at all while the arbiter is idle.
   always_comb begin
      s_adr_o = 32'd0;
      s_dat_o = 32'd0;
      s_sel_o = 4'd0;
      s_we_o  = 1'b0;
      s_cyc_o = 1'b0;
      raw_stb = 1'b0;
      case (state)
         GNT0: begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
            s_we_o  = m0_we_i;
            s_cyc_o = m0_cyc_i;
            raw_stb = m0_stb_i;
         end
         GNT1: begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_we_o  = m1_we_i;
            s_cyc_o = m1_cyc_i;
            raw_stb = m1_stb_i;
         end
         default: begin
         end
      endcase
   end

   // wd holds the number of earlier cycles in the current unacked strobe
   // stretch, so the compare against timeout_cycles-1 fires in the cycle
   // whose index equals timeout_cycles. An ack in that same cycle wins.
   always_comb begin
      timeout_hit = (timeout_cycles != 16'd0) && (state != IDLE) && raw_stb
                    && !s_ack_i && (wd == timeout_cycles - 16'd1);
      if ((timeout_cycles == 16'd0) || (state == IDLE) || !raw_stb
          || s_ack_i || timeout_hit) begin
         wd_next = 16'd0;
      end else begin
         wd_next = wd + 16'd1;
      end
   end

   // The strobe is suppressed in the error cycle so the slave does not
   // take a late ack as a new transfer.
   assign s_stb_o  = raw_stb & ~timeout_hit;

   assign m0_ack_o = s_ack_i & (state == GNT0);
   assign m1_ack_o = s_ack_i & (state == GNT1);
   assign m0_err_o = timeout_hit & (state == GNT0);
   assign m1_err_o = timeout_hit & (state == GNT1);

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

   assign grant_o  = {state == GNT1, state == GNT0};

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_rr_arbiter
//
// Drives two arbiter instances (watchdog at 8 cycles and watchdog disabled)
// with the same master and slave stimulus and compares every output, every
// cycle, against a behavioural model of ownership and unacked stretch length.
// Directed sequences cover single-master access, tie alternation, burst hold,
// timeout, ack/timeout race, long run without watchdog and asynchronous
// reset; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_wb_rr_arbiter;

   int checks = 0;
   int errors = 0;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic [31:0] adr[2];
   logic [31:0] wdat[2];
   logic [3:0]  sel[2];
   logic        we[2];
   logic        cyc[2];
   logic        stb[2];
   logic [31:0] s_dat_in;
   logic        s_ack_in;

   logic [31:0] m0_dat[2];
   logic [31:0] m1_dat[2];
   logic [31:0] s_adr[2];
   logic [31:0] s_dat[2];
   logic [3:0]  s_sel[2];
   logic        s_we[2];
   logic        s_cyc[2];
   logic        s_stb[2];
   logic        m0_ack[2];
   logic        m1_ack[2];
   logic        m0_err[2];
   logic        m1_err[2];
   logic [1:0]  grant[2];

   // Model state: owner 0 = nobody, 1 = m0, 2 = m1; last = index of the
   // most recent owner; stall = cycles already spent in the unacked stretch.
   int owner;
   int last;
   int stall[2];

   // Values seen at the last checked cycle, used by directed checks.
   logic [1:0] obs_grant[2];
   logic       obs_ack0[2];
   logic       obs_ack1[2];
   logic       obs_err0[2];
   logic       obs_err1[2];
   logic       obs_stb[2];

   string nm_ctrl[2];
   string nm_adr[2];
   string nm_dat[2];
   string nm_rd0[2];
   string nm_rd1[2];

   always #5 clk = ~clk;

   wb_rr_arbiter #(.timeout_cycles(16'd8)) u_dut8 (
      .clk(clk), .rst(rst),
      .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_dat_o(m0_dat[0]),
      .m0_sel_i(sel[0]), .m0_we_i(we[0]), .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]),
      .m0_ack_o(m0_ack[0]), .m0_err_o(m0_err[0]),
      .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_dat_o(m1_dat[0]),
      .m1_sel_i(sel[1]), .m1_we_i(we[1]), .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]),
      .m1_ack_o(m1_ack[0]), .m1_err_o(m1_err[0]),
      .s_adr_o(s_adr[0]), .s_dat_o(s_dat[0]), .s_sel_o(s_sel[0]),
      .s_we_o(s_we[0]), .s_cyc_o(s_cyc[0]), .s_stb_o(s_stb[0]),
      .s_dat_i(s_dat_in), .s_ack_i(s_ack_in), .grant_o(grant[0])
   );

   wb_rr_arbiter #(.timeout_cycles(16'd0)) u_dut0 (
      .clk(clk), .rst(rst),
      .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_dat_o(m0_dat[1]),
      .m0_sel_i(sel[0]), .m0_we_i(we[0]), .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]),
      .m0_ack_o(m0_ack[1]), .m0_err_o(m0_err[1]),
      .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_dat_o(m1_dat[1]),
      .m1_sel_i(sel[1]), .m1_we_i(we[1]), .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]),
      .m1_ack_o(m1_ack[1]), .m1_err_o(m1_err[1]),
      .s_adr_o(s_adr[1]), .s_dat_o(s_dat[1]), .s_sel_o(s_sel[1]),
      .s_we_o(s_we[1]), .s_cyc_o(s_cyc[1]), .s_stb_o(s_stb[1]),
      .s_dat_i(s_dat_in), .s_ack_i(s_ack_in), .grant_o(grant[1])
   );

   // Counts one comparison and reports it when it does not match.
   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int tmo(input int d);
      return (d == 0) ? 8 : 0;
   endfunction

   task automatic modelReset();
      owner    = 0;
      last     = 1;
      stall[0] = 0;
      stall[1] = 0;
   endtask

   // Checks one cycle at the falling edge, then advances the model at the
   // rising edge and returns 1 time unit after it.
   task automatic step();
      int         xi;
      bit         g;
      logic       xs;
      logic       e;
      logic [12:0] expc;
      logic [12:0] gotc;
      int         nowner;
      int         nlast;
      int         nstall[2];
      @(negedge clk);
      g  = (owner != 0);
      xi = g ? owner - 1 : 0;
      for (int d = 0; d < 2; d++) begin
         xs = g && stb[xi];
         e  = g && (tmo(d) != 0) && xs && !s_ack_in && (stall[d] + 1 == tmo(d));
         expc = {owner == 2, owner == 1, g && cyc[xi], xs && !e, g && we[xi],
                 g ? sel[xi] : 4'h0, owner == 1 && s_ack_in, owner == 2 && s_ack_in,
                 owner == 1 && e, owner == 2 && e};
         gotc = {grant[d], s_cyc[d], s_stb[d], s_we[d], s_sel[d],
                 m0_ack[d], m1_ack[d], m0_err[d], m1_err[d]};
         checkOutput(nm_ctrl[d], {19'd0, gotc}, {19'd0, expc});
         checkOutput(nm_adr[d], s_adr[d], g ? adr[xi] : 32'd0);
         checkOutput(nm_dat[d], s_dat[d], g ? wdat[xi] : 32'd0);
         checkOutput(nm_rd0[d], m0_dat[d], s_dat_in);
         checkOutput(nm_rd1[d], m1_dat[d], s_dat_in);
         obs_grant[d] = grant[d];
         obs_ack0[d]  = m0_ack[d];
         obs_ack1[d]  = m1_ack[d];
         obs_err0[d]  = m0_err[d];
         obs_err1[d]  = m1_err[d];
         obs_stb[d]   = s_stb[d];
         nstall[d] = (!xs || s_ack_in || e) ? 0 : stall[d] + 1;
      end
      nowner = owner;
      nlast  = last;
      if (owner == 0) begin
         if (cyc[0] && cyc[1]) nowner = (last == 1) ? 1 : 2;
         else if (cyc[0])      nowner = 1;
         else if (cyc[1])      nowner = 2;
      end else if (!cyc[owner - 1]) begin
         nowner = 0;
         nlast  = owner - 1;
      end
      @(posedge clk);
      if (!rst) begin
         modelReset();
      end else begin
         owner    = nowner;
         last     = nlast;
         stall[0] = nstall[0];
         stall[1] = nstall[1];
      end
      #1;
   endtask

   // Drives one cycle of master requests with fresh random payload and a
   // given slave ack, then checks that cycle.
   task automatic applyStimulus(input logic c0, input logic s0, input logic c1,
                                input logic s1, input logic ack);
      cyc[0] = c0;
      stb[0] = s0;
      cyc[1] = c1;
      stb[1] = s1;
      for (int i = 0; i < 2; i++) begin
         adr[i]  = $urandom;
         wdat[i] = $urandom;
         sel[i]  = 4'($urandom);
         we[i]   = 1'($urandom);
      end
      s_dat_in = $urandom;
      s_ack_in = ack;
      step();
   endtask

   // Asserts reset between clock edges and checks both instances go quiet
   // before any clock edge, even with the slave acking.
   task automatic applyReset();
      s_ack_in = 1'b1;
      s_dat_in = $urandom;
      rst = 1'b0;
      #1;
      modelReset();
      for (int d = 0; d < 2; d++) begin
         checkOutput("rst_ctrl",
                     {19'd0, grant[d], s_cyc[d], s_stb[d], s_we[d], s_sel[d],
                      m0_ack[d], m1_ack[d], m0_err[d], m1_err[d]}, 32'd0);
         checkOutput("rst_adr", s_adr[d], 32'd0);
         checkOutput("rst_rdata", m1_dat[d], s_dat_in);
      end
      step();
      step();
      rst = 1'b1;
   endtask

   initial begin
      int acks;
      int m1acks;
      int bad;
      int errcnt;
      int erat;
      logic stbat;
      int cnt8;
      int cnt0;
      logic rc[2];

      nm_ctrl = '{"ctrl_t8", "ctrl_t0"};
      nm_adr  = '{"s_adr_t8", "s_adr_t0"};
      nm_dat  = '{"s_dat_t8", "s_dat_t0"};
      nm_rd0  = '{"m0_dat_t8", "m0_dat_t0"};
      nm_rd1  = '{"m1_dat_t8", "m1_dat_t0"};
      for (int i = 0; i < 2; i++) begin
         adr[i] = 32'd0; wdat[i] = 32'd0; sel[i] = 4'd0;
         we[i] = 1'b0; cyc[i] = 1'b0; stb[i] = 1'b0;
      end
      s_dat_in = 32'd0;
      s_ack_in = 1'b0;
      modelReset();

      // Single master read with ack two cycles after the first strobe cycle.
      applyReset();
      applyStimulus(1, 1, 0, 0, 0);
      checkOutput("single_idle_grant", 32'(obs_grant[0]), 32'd0);
      acks = 0; m1acks = 0;
      applyStimulus(1, 1, 0, 0, 0);
      checkOutput("single_grant", 32'(obs_grant[0]), 32'd1);
      acks += int'(obs_ack0[0]); m1acks += int'(obs_ack1[0]);
      applyStimulus(1, 1, 0, 0, 0);
      acks += int'(obs_ack0[0]); m1acks += int'(obs_ack1[0]);
      applyStimulus(1, 1, 0, 0, 1);
      acks += int'(obs_ack0[0]); m1acks += int'(obs_ack1[0]);
      applyStimulus(0, 0, 0, 0, 0);
      acks += int'(obs_ack0[0]); m1acks += int'(obs_ack1[0]);
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("single_ack_pulses", 32'(acks), 32'd1);
      checkOutput("single_m1_ack", 32'(m1acks), 32'd0);

      // Simultaneous requests from reset, then alternation.
      applyReset();
      applyStimulus(1, 1, 1, 1, 0);
      applyStimulus(1, 1, 1, 1, 1);
      checkOutput("tie_first_m0", 32'(obs_grant[0]), 32'd1);
      applyStimulus(0, 0, 1, 1, 0);
      checkOutput("tie_m0_release", 32'(obs_grant[0]), 32'd1);
      applyStimulus(0, 0, 1, 1, 0);
      checkOutput("tie_dead_cycle", 32'(obs_grant[0]), 32'd0);
      applyStimulus(0, 0, 1, 1, 1);
      checkOutput("tie_then_m1", 32'(obs_grant[0]), 32'd2);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(1, 1, 1, 1, 0);
      checkOutput("tie2_idle", 32'(obs_grant[0]), 32'd0);
      applyStimulus(1, 1, 1, 1, 1);
      checkOutput("tie2_m0", 32'(obs_grant[0]), 32'd1);
      applyStimulus(0, 0, 1, 1, 0);
      applyStimulus(1, 1, 1, 1, 0);

      // Burst hold: m1 owns the bus across four strobe/ack pairs.
      bad = 0; m1acks = 0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 1, 1, 0, 0);
         bad += (obs_grant[0] != 2'b10) ? 1 : 0;
         applyStimulus(1, 1, 1, 1, 1);
         bad += (obs_grant[0] != 2'b10) ? 1 : 0;
         m1acks += int'(obs_ack1[0]);
      end
      checkOutput("burst_grant_held", 32'(bad), 32'd0);
      checkOutput("burst_m1_acks", 32'(m1acks), 32'd4);
      applyStimulus(1, 1, 0, 0, 0);
      applyStimulus(1, 1, 0, 0, 0);
      checkOutput("burst_dead_cycle", 32'(obs_grant[0]), 32'd0);
      applyStimulus(1, 1, 0, 0, 0);
      checkOutput("burst_then_m0", 32'(obs_grant[0]), 32'd1);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);

      // Timeout: slave never acks m0.
      applyStimulus(1, 1, 0, 0, 0);
      errcnt = 0; erat = 0; stbat = 1'b1; bad = 0;
      for (int k = 1; k <= 10; k++) begin
         applyStimulus(1, 1, 0, 0, 0);
         if (obs_err0[0]) begin
            errcnt++;
            erat  = k;
            stbat = obs_stb[0];
         end
         bad += int'(obs_err1[0]) + int'(obs_err0[1]);
      end
      checkOutput("timeout_count", 32'(errcnt), 32'd1);
      checkOutput("timeout_cycle", 32'(erat), 32'd8);
      checkOutput("timeout_stb_low", 32'(stbat), 32'd0);
      checkOutput("timeout_other_err", 32'(bad), 32'd0);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);

      // Ack arriving in the timeout cycle wins.
      applyStimulus(1, 1, 0, 0, 0);
      bad = 0;
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(1, 1, 0, 0, (k == 8) ? 1'b1 : 1'b0);
         bad += int'(obs_err0[0]);
         if (k == 8) checkOutput("race_ack", 32'(obs_ack0[0]), 32'd1);
      end
      checkOutput("race_no_err", 32'(bad), 32'd0);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);

      // Long stall: the disabled watchdog never fires, the 8-cycle one
      // fires on every eighth strobe cycle.
      cnt8 = 0; cnt0 = 0;
      for (int k = 0; k < 70000; k++) begin
         applyStimulus(1, 1, 0, 0, 0);
         cnt8 += int'(obs_err0[0]);
         cnt0 += int'(obs_err0[1]);
      end
      checkOutput("long_err_t0", 32'(cnt0), 32'd0);
      checkOutput("long_err_t8", 32'(cnt8), 32'd8749);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);

      // Reset while m1 owns the bus with a strobe pending.
      applyStimulus(0, 0, 1, 1, 0);
      applyStimulus(0, 0, 1, 1, 0);
      checkOutput("midrst_before", 32'(obs_grant[0]), 32'd2);
      applyReset();
      applyStimulus(1, 1, 1, 1, 0);
      applyStimulus(1, 1, 1, 1, 0);
      checkOutput("midrst_tie_m0", 32'(obs_grant[0]), 32'd1);

      // Randomized traffic with occasional resets.
      rc[0] = 1'b1;
      rc[1] = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < 2; i++) begin
            if (!rc[i]) rc[i] = ($urandom % 4) == 0;
            else        rc[i] = ($urandom % 8) != 0;
         end
         if (($urandom % 200) == 0) begin
            applyReset();
         end else begin
            applyStimulus(rc[0], rc[0] && (($urandom % 8) != 0),
                          rc[1], rc[1] && (($urandom % 8) != 0),
                          ($urandom % 4) == 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
